// File: rtl/crf_job_scheduler.sv
// crf_job_scheduler: queues (source, destination) upsampling jobs and drives
// them into the config register file over an AXI-Lite write-only master.
// Per job: UPSRCAR, UPDSTAR, UPSTR=1, wait for a done rising edge (or
// timeout), then UPENDR=0.
module crf_job_scheduler #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int QUEUE_DEPTH    = 4,
    parameter logic [AXI_ADDR_WIDTH-1:0] UPSTR_ADDR   = 'h00,
    parameter logic [AXI_ADDR_WIDTH-1:0] UPENDR_ADDR  = 'h04,
    parameter logic [AXI_ADDR_WIDTH-1:0] UPSRCAR_ADDR = 'h08,
    parameter logic [AXI_ADDR_WIDTH-1:0] UPDSTAR_ADDR = 'h0C,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [AXI_DATA_WIDTH-1:0]     job_src,
    input  logic [AXI_DATA_WIDTH-1:0]     job_dst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          interrupt_updone,
    output logic                          busy,
    output logic [15:0]                   jobs_done,
    output logic                          err_resp,
    output logic                          err_timeout,
    input  logic                          err_clr
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR_SRC, WR_DST, WR_START, WAIT_DONE, WR_CLR} state_t;

    state_t                      state_reg, state_next;
    logic [AXI_DATA_WIDTH-1:0]   src_mem [QUEUE_DEPTH];
    logic [AXI_DATA_WIDTH-1:0]   dst_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]            count_reg;
    logic [AXI_DATA_WIDTH-1:0]   cur_src_reg, cur_dst_reg;
    logic                        launch_reg, aw_done_reg, w_done_reg;
    logic                        awvalid_reg, wvalid_reg, bready_reg;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_reg;
    logic [AXI_DATA_WIDTH-1:0]   wdata_reg;
    logic                        updone_prev_reg, done_ok_reg;
    logic [TMO_W-1:0]            tmo_cnt_reg;
    logic [15:0]                 jobs_done_reg;
    logic                        err_resp_reg, err_timeout_reg;

    logic push, pop, aw_hs, w_hs, b_hs, updone_rise, tmo_hit, enter_wr;
    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [AXI_DATA_WIDTH-1:0] sel_data;

    assign job_ready   = (count_reg != CNT_W'(QUEUE_DEPTH));
    assign push        = job_valid && job_ready;
    assign pop         = (state_reg == IDLE) && (count_reg != '0);
    assign aw_hs       = awvalid_reg && m_axi_awready;
    assign w_hs        = wvalid_reg && m_axi_wready;
    assign b_hs        = bready_reg && m_axi_bvalid;
    // A level that was already high on entry never produces a rise, because
    // the previous-value register is held high outside WAIT_DONE.
    assign updone_rise = (state_reg == WAIT_DONE) && interrupt_updone && !updone_prev_reg;
    assign tmo_hit     = (state_reg == WAIT_DONE) && !updone_rise && (tmo_cnt_reg == TMO_LAST);
    assign enter_wr    = (state_next != state_reg) &&
                         ((state_next == WR_SRC) || (state_next == WR_DST) ||
                          (state_next == WR_START) || (state_next == WR_CLR));

    // Job storage: plain arrays, no reset, so they map onto RAM
    always_ff @(posedge clk) begin
        if (push) begin
            src_mem[wr_ptr_reg] <= job_src;
            dst_mem[wr_ptr_reg] <= job_dst;
        end
    end

    // Queue pointers/occupancy and the latched current job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            cur_src_reg <= '0;
            cur_dst_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
                cur_src_reg <= src_mem[rd_ptr_reg];
                cur_dst_reg <= dst_mem[rd_ptr_reg];
            end
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (!push && pop) count_reg <= count_reg - CNT_W'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (pop)  state_next = WR_SRC;
            WR_SRC:    if (b_hs) state_next = WR_DST;
            WR_DST:    if (b_hs) state_next = WR_START;
            WR_START:  if (b_hs) state_next = WAIT_DONE;
            WAIT_DONE: if (updone_rise || tmo_hit) state_next = WR_CLR;
            WR_CLR:    if (b_hs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Register address/data for the write belonging to the current state
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (state_reg)
            WR_SRC:   begin sel_addr = UPSRCAR_ADDR; sel_data = cur_src_reg; end
            WR_DST:   begin sel_addr = UPDSTAR_ADDR; sel_data = cur_dst_reg; end
            WR_START: begin sel_addr = UPSTR_ADDR;   sel_data = AXI_DATA_WIDTH'(1); end
            WR_CLR:   begin sel_addr = UPENDR_ADDR;  sel_data = '0; end
            default:  begin sel_addr = '0;           sel_data = '0; end
        endcase
    end

    // Write engine: launch one cycle after state entry, drop each valid on its
    // own handshake, raise bready once both AW and W are done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
        end else begin
            launch_reg <= enter_wr;
            if (launch_reg) begin
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
                awaddr_reg  <= sel_addr;
                wdata_reg   <= sel_data;
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    awvalid_reg <= 1'b0;
                    aw_done_reg <= 1'b1;
                end
                if (w_hs) begin
                    wvalid_reg <= 1'b0;
                    w_done_reg <= 1'b1;
                end
                if (b_hs) begin
                    bready_reg  <= 1'b0;
                    aw_done_reg <= 1'b0;
                    w_done_reg  <= 1'b0;
                end else if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    bready_reg <= 1'b1;
                end
            end
        end
    end

    // Done edge detection, timeout counter, completion count and sticky errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            updone_prev_reg <= 1'b1;
            tmo_cnt_reg     <= '0;
            done_ok_reg     <= 1'b0;
            jobs_done_reg   <= '0;
            err_resp_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            updone_prev_reg <= (state_reg == WAIT_DONE) ? interrupt_updone : 1'b1;
            tmo_cnt_reg     <= (state_reg == WAIT_DONE) ? tmo_cnt_reg + TMO_W'(1) : '0;
            if ((state_reg == WAIT_DONE) && (state_next == WR_CLR))
                done_ok_reg <= updone_rise;
            if ((state_reg == WR_CLR) && b_hs && done_ok_reg)
                jobs_done_reg <= jobs_done_reg + 16'd1;
            if (b_hs && (m_axi_bresp != 2'b00)) err_resp_reg <= 1'b1;
            else if (err_clr)                   err_resp_reg <= 1'b0;
            if (tmo_hit)      err_timeout_reg <= 1'b1;
            else if (err_clr) err_timeout_reg <= 1'b0;
        end
    end

    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = bready_reg;
    assign busy          = (state_reg != IDLE) || (count_reg != '0);
    assign jobs_done     = jobs_done_reg;
    assign err_resp      = err_resp_reg;
    assign err_timeout   = err_timeout_reg;

endmodule

// File: tb/tb_crf_job_scheduler.sv
// Directed bench for crf_job_scheduler: a configurable AXI-Lite slave model
// and write logger around the main instance, plus a second instance with a
// short timeout for the abort path.
module tb_crf_job_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        rst_n, job_valid, job_ready, awvalid, awready, wvalid, wready;
    logic        bvalid, bready, updone, busy, err_resp, err_timeout, err_clr;
    logic [31:0] job_src, job_dst, awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [15:0] jobs_done;

    // timeout instance signals
    logic        job_valid_t, job_ready_t, awvalid_t, awready_t, wvalid_t, wready_t;
    logic        bvalid_t, bready_t, updone_t, busy_t, err_resp_t, err_timeout_t, err_clr_t;
    logic [31:0] job_src_t, job_dst_t, awaddr_t, wdata_t;
    logic [2:0]  awprot_t;
    logic [3:0]  wstrb_t;
    logic [1:0]  bresp_t;
    logic [15:0] jobs_done_t;

    crf_job_scheduler dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
        .job_src(job_src), .job_dst(job_dst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
        .m_axi_awprot(awprot), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready), .m_axi_bresp(bresp), .interrupt_updone(updone),
        .busy(busy), .jobs_done(jobs_done), .err_resp(err_resp),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    crf_job_scheduler #(.TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid_t), .job_ready(job_ready_t),
        .job_src(job_src_t), .job_dst(job_dst_t),
        .m_axi_awvalid(awvalid_t), .m_axi_awready(awready_t), .m_axi_awaddr(awaddr_t),
        .m_axi_awprot(awprot_t), .m_axi_wvalid(wvalid_t), .m_axi_wready(wready_t),
        .m_axi_wdata(wdata_t), .m_axi_wstrb(wstrb_t), .m_axi_bvalid(bvalid_t),
        .m_axi_bready(bready_t), .m_axi_bresp(bresp_t), .interrupt_updone(updone_t),
        .busy(busy_t), .jobs_done(jobs_done_t), .err_resp(err_resp_t),
        .err_timeout(err_timeout_t), .err_clr(err_clr_t)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // slave model knobs
    int          aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] err_addr = 32'hFF;
    bit          auto_en = 1'b1, manual_en = 1'b0, updone_manual = 1'b0, auto_pulse = 1'b0;
    int          done_delay = 50;
    int          done_arm = -1000000;
    assign updone = manual_en ? updone_manual : auto_pulse;

    // write log of the main instance
    int          cyc = 0;
    int          wr_n = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_start [64];
    int          wr_aw [64];
    int          wr_w [64];
    int          wr_br [64];
    int          wr_b [64];
    bit          aw_got = 0, w_got = 0, started = 0, br_seen = 0;
    bit          prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_w_hs = 0;
    logic [31:0] prev_awaddr = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    // write log of the timeout instance
    int          to_n = 0;
    logic [31:0] to_addr [16];
    logic [31:0] to_data [16];
    int          to_b [16];

    // Monitor: protocol checks and handshake logging at the active edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            aw_got = 0; w_got = 0; started = 0; br_seen = 0;
            prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_w_hs = 0;
        end else begin
            if (prev_awv && !prev_awr) begin
                check("aw_hold", awvalid, 1);
                check("aw_addr_stable", awaddr, prev_awaddr);
            end
            if (prev_wv && !prev_wr) check("w_hold", wvalid, 1);
            if (prev_w_hs) check("w_drop", wvalid, 0);
            if (bready) check("bready_after_aw_w", aw_got && w_got, 1);
            if (wr_n < 64) begin
                if (awvalid && !started) begin started = 1; wr_start[wr_n] = cyc; end
                if (awvalid && awready) begin aw_got = 1; wr_addr[wr_n] = awaddr; wr_aw[wr_n] = cyc; end
                if (wvalid && wready) begin w_got = 1; wr_data[wr_n] = wdata; wr_w[wr_n] = cyc; end
                if (bready && !br_seen) begin br_seen = 1; wr_br[wr_n] = cyc; end
                if (bvalid && bready) begin
                    wr_b[wr_n] = cyc;
                    $display("[TB] write %0d addr=%h data=%h bresp=%0d cyc=%0d", wr_n, wr_addr[wr_n], wr_data[wr_n], bresp, cyc);
                    if (wr_addr[wr_n] == 32'h00) done_arm = cyc;
                    wr_n = wr_n + 1;
                    aw_got = 0; w_got = 0; started = 0; br_seen = 0;
                end
            end
            prev_awv = awvalid; prev_awr = awready; prev_awaddr = awaddr;
            prev_wv = wvalid; prev_wr = wready; prev_w_hs = wvalid && wready;
            if (to_n < 16) begin
                if (awvalid_t && awready_t) to_addr[to_n] = awaddr_t;
                if (wvalid_t && wready_t) to_data[to_n] = wdata_t;
                if (bvalid_t && bready_t) begin
                    to_b[to_n] = cyc;
                    $display("[TB] to-write %0d addr=%h data=%h cyc=%0d", to_n, to_addr[to_n], to_data[to_n], cyc);
                    to_n = to_n + 1;
                end
            end
        end
    end

    // Slave responses and done pulse, updated on the inactive edge
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; auto_pulse = 0; bvalid_t = 0;
        end else begin
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 0; w_cnt = 0; end
            if (aw_got && w_got) begin
                if (!bvalid) begin
                    if (b_cnt >= b_delay) begin
                        bvalid = 1;
                        bresp  = (wr_addr[wr_n] == err_addr) ? 2'b10 : 2'b00;
                    end else b_cnt++;
                end
            end else begin
                bvalid = 0; b_cnt = 0; bresp = 2'b00;
            end
            auto_pulse = auto_en && (cyc == done_arm + done_delay);
            bvalid_t   = bready_t;
        end
    end

    task automatic push(input bit to_side, input logic [31:0] s, input logic [31:0] d);
        int k = 0;
        if (!to_side) begin
            job_valid = 1; job_src = s; job_dst = d;
            while (!job_ready && k < 2000) begin @(negedge clk); k++; end
            check("push_ready", job_ready, 1);
            @(negedge clk);
            job_valid = 0;
        end else begin
            job_valid_t = 1; job_src_t = s; job_dst_t = d;
            while (!job_ready_t && k < 2000) begin @(negedge clk); k++; end
            check("push_ready_t", job_ready_t, 1);
            @(negedge clk);
            job_valid_t = 0;
        end
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (wr_n < n && k < 3000) begin @(negedge clk); k++; end
        check("wait_writes", wr_n, n);
    endtask

    task automatic wait_to(input int n);
        int k = 0;
        while (to_n < n && k < 3000) begin @(negedge clk); k++; end
        check("wait_to_writes", to_n, n);
    endtask

    task automatic check_job(input int i, input logic [31:0] s, input logic [31:0] d);
        check("src_addr",   wr_addr[i],   32'h08); check("src_data",   wr_data[i],   s);
        check("dst_addr",   wr_addr[i+1], 32'h0C); check("dst_data",   wr_data[i+1], d);
        check("start_addr", wr_addr[i+2], 32'h00); check("start_data", wr_data[i+2], 32'h1);
        check("clr_addr",   wr_addr[i+3], 32'h04); check("clr_data",   wr_data[i+3], 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int base, base_t, e, r, exp_done;

    initial begin
        rst_n = 0; job_valid = 0; job_src = 0; job_dst = 0; err_clr = 0;
        job_valid_t = 0; job_src_t = 0; job_dst_t = 0; err_clr_t = 0;
        awready_t = 1; wready_t = 1; bresp_t = 2'b00; updone_t = 0;
        exp_done = 0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_err_resp", err_resp, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_job_ready", job_ready, 1);
        rst_n = 1;
        @(negedge clk);

        // single job, done 50 cycles after the UPSTR write
        done_delay = 50;
        base = wr_n;
        push(0, 32'h1000_0000, 32'h2000_0000);
        check("single_busy", busy, 1);
        wait_wr(base + 4);
        repeat (5) @(negedge clk);
        check("single_count", wr_n, base + 4);
        check_job(base, 32'h1000_0000, 32'h2000_0000);
        exp_done = exp_done + 1;
        check("single_jobs_done", jobs_done, exp_done);
        check("single_busy_after", busy, 0);
        check("awprot", awprot, 0);
        check("wstrb", wstrb, 4'hF);

        // back-to-back: five jobs, queue fills behind the running one
        done_delay = 5;
        base = wr_n;
        for (int j = 0; j < 5; j++) push(0, 32'hA000_0000 + j * 32'h100, 32'hB000_0000 + j);
        check("b2b_full_ready", job_ready, 0);
        wait_wr(base + 4);
        check("b2b_ready_before_pop", job_ready, 0);
        @(negedge clk);
        check("b2b_ready_after_pop", job_ready, 1);
        wait_wr(base + 20);
        repeat (5) @(negedge clk);
        for (int j = 0; j < 5; j++) check_job(base + 4 * j, 32'hA000_0000 + j * 32'h100, 32'hB000_0000 + j);
        exp_done = exp_done + 5;
        check("b2b_jobs_done", jobs_done, exp_done);
        check("b2b_busy_after", busy, 0);

        // backpressure: AW accepted after 3 cycles, W at once, B 2 cycles later
        aw_delay = 3; w_delay = 0; b_delay = 2;
        base = wr_n;
        push(0, 32'h3000_0040, 32'h4000_0080);
        wait_wr(base + 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_aw_wait", wr_aw[base+i] - wr_start[base+i], 3);
            check("bp_w_wait", wr_w[base+i] - wr_start[base+i], 0);
            check("bp_bready_start", wr_br[base+i] - wr_aw[base+i], 1);
            check("bp_b_hs", wr_b[base+i] - wr_aw[base+i], 3);
        end
        check_job(base, 32'h3000_0040, 32'h4000_0080);
        aw_delay = 0; b_delay = 0;
        repeat (5) @(negedge clk);
        exp_done = exp_done + 1;
        check("bp_jobs_done", jobs_done, exp_done);

        // error response on the UPDSTAR write
        err_addr = 32'h0C;
        check("err_before", err_resp, 0);
        base = wr_n;
        push(0, 32'h5000_0000, 32'h6000_0000);
        wait_wr(base + 1);
        check("err_after_src", err_resp, 0);
        wait_wr(base + 2);
        check("err_set", err_resp, 1);
        wait_wr(base + 4);
        repeat (3) @(negedge clk);
        check("err_sticky", err_resp, 1);
        check_job(base, 32'h5000_0000, 32'h6000_0000);
        exp_done = exp_done + 1;
        check("err_jobs_done", jobs_done, exp_done);
        err_addr = 32'hFF;
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("err_cleared", err_resp, 0);

        // timeout on the short-timeout instance, done never asserted
        base_t = to_n;
        push(1, 32'h7000_0000, 32'h8000_0000);
        wait_to(base_t + 3);
        e = to_b[base_t + 2];
        while (cyc < e + 15) @(negedge clk);
        check("tmo_not_yet", err_timeout_t, 0);
        @(negedge clk);
        check("tmo_set", err_timeout_t, 1);
        wait_to(base_t + 4);
        check("tmo_clr_addr", to_addr[base_t + 3], 32'h04);
        check("tmo_clr_data", to_data[base_t + 3], 32'h0);
        repeat (3) @(negedge clk);
        check("tmo_jobs_done", jobs_done_t, 0);
        check("tmo_busy_after", busy_t, 0);
        check("tmo_err_sticky", err_timeout_t, 1);

        // stale done: high on entry, low 5 cycles, then high again
        manual_en = 1; updone_manual = 1;
        base = wr_n;
        push(0, 32'h9000_0000, 32'h9100_0000);
        wait_wr(base + 3);
        repeat (8) @(negedge clk);
        check("stale_no_clr", wr_n, base + 3);
        check("stale_no_awvalid", awvalid, 0);
        updone_manual = 0;
        repeat (5) @(negedge clk);
        updone_manual = 1;
        r = cyc;
        wait_wr(base + 4);
        check("stale_clr_start", wr_start[base + 3], r + 3);
        check_job(base, 32'h9000_0000, 32'h9100_0000);
        repeat (3) @(negedge clk);
        exp_done = exp_done + 1;
        check("stale_jobs_done", jobs_done, exp_done);
        manual_en = 0; updone_manual = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
